// File: rtl/mem_port_arbiter.sv
// Single-port memory scheduler shared by instruction fetch and data load/store.
// Each access runs WAIT_CYCLES+1 enable cycles, then a one-cycle acknowledge to the winner.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            GNT_IF   = 1'b0;
    localparam logic            GNT_D    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_sel_q, grant_sel_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                busy_q, busy_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                grant_vld_s;
    logic                grant_port_s;
    logic                access_done_s;

    // Round-robin pick: on a conflict the port that did not win last time is served.
    always_comb begin
        grant_vld_s  = 1'b0;
        grant_port_s = GNT_IF;
        if (if_req && d_req) begin
            grant_vld_s  = 1'b1;
            grant_port_s = (last_grant_q == GNT_D) ? GNT_IF : GNT_D;
        end else if (if_req) begin
            grant_vld_s  = 1'b1;
            grant_port_s = GNT_IF;
        end else if (d_req) begin
            grant_vld_s  = 1'b1;
            grant_port_s = GNT_D;
        end else begin
            grant_vld_s  = 1'b0;
            grant_port_s = GNT_IF;
        end
    end

    assign access_done_s = (state_q == ST_ACCESS) && (cnt_q == {CNT_W{1'b0}});

    // Next-state, wait counter and grant bookkeeping.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_sel_d  = grant_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_d      = ST_ACCESS;
                    cnt_d        = CNT_LOAD;
                    grant_sel_d  = grant_port_s;
                    last_grant_d = grant_port_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (access_done_s) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Request latching and read-data capture on the final access edge.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if ((state_q == ST_IDLE) && grant_vld_s) begin
            if (grant_port_s == GNT_D) begin
                mem_addr_d  = d_addr;
                mem_wdata_d = d_wdata;
                mem_we_d    = d_we;
            end else begin
                mem_addr_d  = if_addr;
                mem_wdata_d = {DATA_W{1'b0}};
                mem_we_d    = 1'b0;
            end
        end else if (access_done_s) begin
            mem_we_d = 1'b0;
            if (!mem_we_q) begin
                if (grant_sel_q == GNT_IF) begin
                    if_rdata_d = mem_rdata;
                end else begin
                    d_rdata_d = mem_rdata;
                end
            end else begin
                d_rdata_d = d_rdata_q;
            end
        end else begin
            mem_we_d = (state_q == ST_ACCESS) ? mem_we_q : 1'b0;
        end
    end

    // Control outputs decoded from the upcoming state so they leave the flops aligned with it.
    always_comb begin
        mem_en_d = 1'b0;
        busy_d   = 1'b0;
        if_ack_d = 1'b0;
        d_ack_d  = 1'b0;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_ACCESS: begin
                mem_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_RESP: begin
                busy_d   = 1'b1;
                if_ack_d = (grant_sel_d == GNT_IF);
                d_ack_d  = (grant_sel_d == GNT_D);
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= GNT_D;
            grant_sel_q  <= GNT_IF;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            mem_we_q     <= 1'b0;
            if_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
            mem_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_sel_q  <= grant_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            busy_q       <= busy_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Multicycle-core memory scheduler. Shares one single-port unified instruction/data memory between two requesters: the instruction-fetch path (driven when the control unit asserts load_ir) and the data path (loads/stores).
- Sequences each access over a configurable number of wait states. Returns read data and a one-cycle acknowledge to the winning requester.
- Round-robin arbitration when both ports request on the same cycle.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- WAIT_CYCLES, 2, extra memory wait states per access; 0 is legal.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  output  DATA_W  last fetched word (registered).
- if_ack  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_rdata  output  DATA_W  last loaded word (registered).
- d_ack  output  1  one-cycle data completion pulse.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid in the final ACCESS cycle.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, last_grant=DATA. if_ack, d_ack, mem_en, mem_we, busy = 0. mem_addr, mem_wdata, if_rdata, d_rdata = 0. Outputs drop immediately, not at the next edge.
- States: IDLE, ACCESS, RESP.
- IDLE, requests are sampled at each rising edge:
  - Neither request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that is not last_grant. Out of reset, fetch wins the first conflict.
  - On grant: register grant_sel, set last_grant=grant_sel, latch address/we/wdata from the granted port into mem_addr/mem_we/mem_wdata, load counter=WAIT_CYCLES, go to ACCESS.
  - Fetch grants always set mem_we=0.
- ACCESS:
  - mem_en=1. mem_addr/mem_we/mem_wdata held constant.
  - Counter decrements each cycle. When counter==0 at the rising edge, go to RESP.
  - ACCESS lasts exactly WAIT_CYCLES+1 cycles.
  - On the exiting edge of a load or fetch, capture mem_rdata into d_rdata or if_rdata respectively.
  - A store never modifies d_rdata.
- RESP: exactly one cycle. mem_en=0, mem_we=0. Assert if_ack or d_ack per grant_sel (never both). Always return to IDLE.
- Latency: request high in cycle 0, mem_en high in cycles 1..WAIT_CYCLES+1, ack high in cycle WAIT_CYCLES+2. Ack is visible WAIT_CYCLES+2 edges after the request edge.
- Back-to-back: a port that does not drop its request in the ack cycle is seen as a new request on the following IDLE edge. Minimum transaction spacing is WAIT_CYCLES+3 cycles.
- Losing port: keeps its request high and is granted on the next IDLE edge, so it waits at most one full transaction.
- Request withdrawn mid-ACCESS (protocol violation): the transaction still completes and ack is still pulsed. Ports are never aborted except by reset.
- Port inputs are ignored while not in IDLE. Latched values are used for the whole access.
- if_rdata and d_rdata hold their value until the next completed read on the same port.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1 bit. The counter does not wrap: it is loaded only in IDLE.
- Reset asserted mid-ACCESS or mid-RESP: the transaction is abandoned with no ack and no rdata update. After release, arbitration restarts from last_grant=DATA.

Test Plan:
- Reset: hold reset=0 with both requests high -> all outputs 0, busy=0. Release reset -> first grant goes to fetch.
- Fetch, WAIT_CYCLES=2: if_req=1, if_addr=0x10, mem_rdata=0x00500093 -> mem_en=1 with mem_addr=0x10, mem_we=0 for cycles 1-3; if_ack=1 in cycle 4 only; if_rdata=0x00500093.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF for 3 cycles; d_ack pulse in cycle 4; d_rdata unchanged from its prior value.
- Conflict: both requests asserted and held -> sequence fetch, data, fetch, data. Each ack is 5 cycles after the previous one, and no ack overlaps another.
- Reset mid-ACCESS: assert reset=0 in cycle 2 of a load -> mem_en falls immediately, no d_ack, d_rdata keeps its old value. After release, the same request completes normally.
- WAIT_CYCLES=0 instance: load from 0x8 -> mem_en for 1 cycle; d_ack in cycle 2; back-to-back requests acked every 3 cycles.
